// File: rtl/rvfi_harness_pkg.sv
// Shared types and helpers for the RVFI harness sequencing blocks.
// Holds the reset-FSM state type, default timing constants and saturating arithmetic.
package rvfi_harness_pkg;

  typedef enum logic {
    RST_HOLD = 1'b0,
    RUN      = 1'b1
  } rst_state_e;

  localparam int DEFAULT_CHECK_CYCLE = 20;
  localparam int DEFAULT_MAX_WAIT    = 4;

  function automatic int unsigned popcount(input logic [31:0] vec);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += {31'b0, vec[i]};
    return n;
  endfunction

  // Adds inc to val and clamps at max_val instead of wrapping.
  function automatic int unsigned sat_inc(input int unsigned val, input int unsigned inc,
                                          input int unsigned max_val);
    return (val + inc >= max_val) ? max_val : val + inc;
  endfunction

endpackage

// File: rtl/rvfi_stall_monitor.sv
// Tracks consecutive memory wait-states on one bus port and flags runs longer than MAX_WAIT.
// Kept separate so multi-port cores can instantiate one monitor per port.
module rvfi_stall_monitor
  import rvfi_harness_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic mem_valid,
  input  logic mem_ready,
  output logic stall_run_over,
  output logic stall_viol
);

  localparam int WW = $clog2(MAX_WAIT + 2);

  logic [WW-1:0] wait_cnt;
  logic          stalled;

  assign stalled        = mem_valid && !mem_ready;
  // Fires on the first cycle past the permitted run, not on later ones (counter saturates above).
  assign stall_run_over = (wait_cnt == WW'(MAX_WAIT)) && stalled;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt   <= '0;
      stall_viol <= 1'b0;
    end else begin
      if (run && stalled) wait_cnt <= WW'(sat_inc(32'(wait_cnt), 1, MAX_WAIT + 1));
      else                wait_cnt <= '0;
      if (stall_run_over) stall_viol <= 1'b1;
    end
  end

endmodule

// File: rtl/rvfi_check_sequencer.sv
// Sequences core reset release, counts cycles, opens the check window and gates RVFI retirements.
// Produces the env_ok constraint flag from stall and trap monitoring.
module rvfi_check_sequencer
  import rvfi_harness_pkg::*;
#(
  parameter int NRET        = 1,
  parameter int RST_CYCLES  = 1,
  parameter int CHECK_CYCLE = DEFAULT_CHECK_CYCLE,
  parameter int WINDOW      = 1,
  parameter int MAX_WAIT    = DEFAULT_MAX_WAIT,
  parameter int CW          = 8
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            core_resetn,
  input  logic            trap,
  input  logic            mem_valid,
  input  logic            mem_ready,
  input  logic [NRET-1:0] rvfi_valid_in,
  output logic [NRET-1:0] rvfi_valid_out,
  output logic            check_en,
  output logic [CW-1:0]   cycle,
  output logic [7:0]      checked_cnt,
  output logic            stall_viol,
  output logic            trap_seen,
  output logic            env_ok,
  output logic            done
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] CYCLE_MAX = '1;
  localparam logic [CW-1:0] WIN_LO    = CW'(CHECK_CYCLE);
  localparam logic [CW-1:0] WIN_HI    = CW'(CHECK_CYCLE + WINDOW - 1);

  rst_state_e     state_q, state_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic           core_resetn_d;
  logic           run;
  logic [CW-1:0]  cycle_d;
  logic           check_en_d;
  logic [7:0]     checked_cnt_d;
  logic           stall_run_over;

  // NOTE: every signal assigned in this always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    core_resetn_d = 1'b0;
    case (state_q)
      RST_HOLD: begin
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) state_d = RUN;
        else                                   rst_cnt_d = rst_cnt_q + RCW'(1);
      end
      RUN:      state_d = RUN;
      default:  state_d = RST_HOLD;
    endcase
    core_resetn_d = (state_d == RUN);
  end

  assign run     = (state_q == RUN);
  assign cycle_d = run ? CW'(sat_inc(32'(cycle), 1, 32'(CYCLE_MAX))) : cycle;

  // Registering against the upcoming cycle value aligns check_en with cycle itself.
  assign check_en_d = run && (cycle_d >= WIN_LO) && (cycle_d <= WIN_HI);

  // A plain AND forces the output to 0 whenever check_en is low, even with X on the input.
  assign rvfi_valid_out = rvfi_valid_in & {NRET{check_en}};
  assign checked_cnt_d  = 8'(sat_inc(32'(checked_cnt), popcount(32'(rvfi_valid_out)), 255));

  assign env_ok = !stall_viol && !trap_seen && !stall_run_over;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RST_HOLD;
      rst_cnt_q   <= '0;
      core_resetn <= 1'b0;
      cycle       <= '0;
      check_en    <= 1'b0;
      checked_cnt <= '0;
      trap_seen   <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      core_resetn <= core_resetn_d;
      cycle       <= cycle_d;
      check_en    <= check_en_d;
      checked_cnt <= checked_cnt_d;
      if (trap && run)              trap_seen <= 1'b1;
      if (check_en && !check_en_d)  done      <= 1'b1;
    end
  end

  rvfi_stall_monitor #(
    .MAX_WAIT(MAX_WAIT)
  ) u_stall_monitor (
    .clk           (clk),
    .resetn        (resetn),
    .run           (run),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .stall_run_over(stall_run_over),
    .stall_viol    (stall_viol)
  );

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Self-checking bench for rvfi_check_sequencer: a cycle-level reference model feeds a
// scoreboard queue each cycle, plus directed checks on the scenario milestones.
module tb_rvfi_check_sequencer;

  localparam int NRET        = 2;
  localparam int RST_CYCLES  = 2;
  localparam int CHECK_CYCLE = 20;
  localparam int WINDOW      = 3;
  localparam int MAX_WAIT    = 4;
  localparam int CW          = 8;

  logic            clk;
  logic            resetn;
  logic            core_resetn;
  logic            trap;
  logic            mem_valid;
  logic            mem_ready;
  logic [NRET-1:0] rvfi_valid_in;
  logic [NRET-1:0] rvfi_valid_out;
  logic            check_en;
  logic [CW-1:0]   cycle;
  logic [7:0]      checked_cnt;
  logic            stall_viol;
  logic            trap_seen;
  logic            env_ok;
  logic            done;

  rvfi_check_sequencer #(
    .NRET(NRET), .RST_CYCLES(RST_CYCLES), .CHECK_CYCLE(CHECK_CYCLE),
    .WINDOW(WINDOW), .MAX_WAIT(MAX_WAIT), .CW(CW)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .core_resetn   (core_resetn),
    .trap          (trap),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .rvfi_valid_in (rvfi_valid_in),
    .rvfi_valid_out(rvfi_valid_out),
    .check_en      (check_en),
    .cycle         (cycle),
    .checked_cnt   (checked_cnt),
    .stall_viol    (stall_viol),
    .trap_seen     (trap_seen),
    .env_ok        (env_ok),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            core_resetn;
    logic            check_en;
    logic [CW-1:0]   cycle;
    logic [7:0]      checked_cnt;
    logic [NRET-1:0] vout;
    logic            stall_viol;
    logic            trap_seen;
    logic            env_ok;
    logic            done;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_n  = 0;

  // Reference model state: edges since reset release, retirements, stall run length, stickies.
  int m_edges, m_cnt, m_wait;
  bit m_sv, m_ts;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_edges = 0;
    m_cnt   = 0;
    m_wait  = 0;
    m_sv    = 1'b0;
    m_ts    = 1'b0;
  endfunction

  function automatic obs_t model_out();
    obs_t e;
    int   cyc;
    e.core_resetn = resetn && (m_edges >= RST_CYCLES);
    cyc = e.core_resetn ? m_edges - RST_CYCLES : 0;
    if (cyc > 255) cyc = 255;
    e.cycle       = 8'(cyc);
    e.check_en    = e.core_resetn && (cyc >= CHECK_CYCLE) && (cyc < CHECK_CYCLE + WINDOW);
    e.done        = e.core_resetn && (cyc >= CHECK_CYCLE + WINDOW);
    e.vout        = e.check_en ? rvfi_valid_in : '0;
    e.checked_cnt = 8'(m_cnt);
    e.stall_viol  = m_sv;
    e.trap_seen   = m_ts;
    e.env_ok      = !m_sv && !m_ts &&
                    !(e.core_resetn && mem_valid && !mem_ready && m_wait == MAX_WAIT);
    return e;
  endfunction

  function automatic void model_edge(input obs_t e);
    int pc;
    bit stalled;
    pc = 0;
    for (int i = 0; i < NRET; i++) pc += int'(e.vout[i]);
    m_cnt   = (m_cnt + pc > 255) ? 255 : m_cnt + pc;
    stalled = mem_valid && !mem_ready;
    if (e.core_resetn && stalled && m_wait == MAX_WAIT) m_sv = 1'b1;
    if (e.core_resetn && trap) m_ts = 1'b1;
    m_wait  = (e.core_resetn && stalled) ? m_wait + 1 : 0;
    m_edges++;
  endfunction

  task automatic compare_out();
    obs_t  e;
    string t;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_empty: no expected entry at step %0d", step_n);
      return;
    end
    e = exp_q.pop_front();
    t = $sformatf("s%0d", step_n);
    check({t, " core_resetn"}, 32'(core_resetn),    32'(e.core_resetn));
    check({t, " check_en"},    32'(check_en),       32'(e.check_en));
    check({t, " cycle"},       32'(cycle),          32'(e.cycle));
    check({t, " checked_cnt"}, 32'(checked_cnt),    32'(e.checked_cnt));
    check({t, " valid_out"},   32'(rvfi_valid_out), 32'(e.vout));
    check({t, " stall_viol"},  32'(stall_viol),     32'(e.stall_viol));
    check({t, " trap_seen"},   32'(trap_seen),      32'(e.trap_seen));
    check({t, " env_ok"},      32'(env_ok),         32'(e.env_ok));
    check({t, " done"},        32'(done),           32'(e.done));
  endtask

  // Called at a negedge: drive, let combinational paths settle, score, then take one clock edge.
  task automatic step(input logic rn, input logic [NRET-1:0] vin, input logic tr,
                      input logic mv, input logic mr);
    obs_t e;
    resetn        = rn;
    rvfi_valid_in = vin;
    trap          = tr;
    mem_valid     = mv;
    mem_ready     = mr;
    if (!rn) model_reset();
    #1;
    e = model_out();
    exp_q.push_back(e);
    compare_out();
    @(posedge clk);
    if (resetn) model_edge(e);
    @(negedge clk);
    step_n++;
  endtask

  task automatic run_cycles(input int n, input logic [NRET-1:0] vin, input logic tr,
                            input logic mv, input logic mr);
    for (int i = 0; i < n; i++) step(1'b1, vin, tr, mv, mr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn        = 1'b0;
    trap          = 1'b0;
    mem_valid     = 1'b0;
    mem_ready     = 1'b0;
    rvfi_valid_in = '0;
    model_reset();
    @(negedge clk);

    // Reset held 3 cycles, then a 2-cycle hold; trap during hold must be ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    check("t1_core_rst_edge1", 32'(core_resetn), 32'(0));
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    check("t1_core_rst_edge2", 32'(core_resetn), 32'(1));
    check("t1_cycle_start",    32'(cycle),       32'(0));
    check("t5_trap_in_hold",   32'(trap_seen),   32'(0));

    // Run 1: a permitted 4-cycle stall, the window on channel 0, then a 5-cycle stall.
    run_cycles(2, 2'b00, 1'b0, 1'b0, 1'b0);
    run_cycles(4, 2'b00, 1'b0, 1'b1, 1'b0);
    run_cycles(1, 2'b00, 1'b0, 1'b1, 1'b1);
    check("t4_no_viol_4", 32'(stall_viol), 32'(0));
    check("t4_env_ok_4",  32'(env_ok),     32'(1));
    run_cycles(23, 2'b01, 1'b0, 1'b0, 1'b0);
    check("t2_checked_cnt", 32'(checked_cnt), 32'(3));
    check("t2_done",        32'(done),        32'(1));
    check("t2_check_en",    32'(check_en),    32'(0));
    run_cycles(5, 2'b10, 1'b0, 1'b1, 1'b0);
    check("t4_viol_5",    32'(stall_viol), 32'(1));
    check("t4_env_ok_5",  32'(env_ok),     32'(0));
    step(1'b1, 2'bxx, 1'b0, 1'b0, 1'b0);
    check("xprop_gated", 32'(rvfi_valid_out), 32'(0));

    // Run 2: trap at cycle 7, both channels active, reset asserted at cycle 21 inside the window.
    for (int i = 0; i < 2; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    check("t6_viol_cleared", 32'(stall_viol), 32'(0));
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    run_cycles(7, 2'b11, 1'b0, 1'b0, 1'b0);
    check("t5_no_trap_yet", 32'(trap_seen), 32'(0));
    step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    check("t5_trap_seen", 32'(trap_seen), 32'(1));
    check("t5_env_ok",    32'(env_ok),    32'(0));
    run_cycles(13, 2'b11, 1'b0, 1'b0, 1'b0);
    check("t6_pre_cycle", 32'(cycle),       32'(21));
    check("t6_pre_cnt",   32'(checked_cnt), 32'(2));
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    check("t6_check_en",  32'(check_en),       32'(0));
    check("t6_cycle",     32'(cycle),          32'(0));
    check("t6_cnt",       32'(checked_cnt),    32'(0));
    check("t6_done",      32'(done),           32'(0));
    check("t6_valid_out", 32'(rvfi_valid_out), 32'(0));

    // Run 3: trap on the same cycle the stall run overflows, full window, then cycle saturation.
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    run_cycles(3, 2'b00, 1'b0, 1'b0, 1'b0);
    run_cycles(4, 2'b00, 1'b0, 1'b1, 1'b0);
    check("t4_viol_pending", 32'(stall_viol), 32'(0));
    step(1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
    check("both_viol", 32'(stall_viol), 32'(1));
    check("both_trap", 32'(trap_seen),  32'(1));
    run_cycles(260, 2'b11, 1'b0, 1'b0, 1'b0);
    check("t3_checked_cnt", 32'(checked_cnt), 32'(6));
    check("cycle_sat",      32'(cycle),       32'(255));
    check("done_sticky",    32'(done),        32'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
